// File: rtl/dma_job_sched.sv
// rtl/dma_job_sched.sv - three-requester DMA job scheduler with 256-beat / 4 KB chunk splitting
//
// Accepts whole-job requests from three requesters (0 dat, 1 wt, 2 cfg), grants one at a time
// round-robin, and issues the job to the DMA as chunks that never exceed 256 beats and never
// cross a 4 KB boundary. Each chunk is watched by a timeout counter; an expired chunk aborts
// the job with req_err.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_vld[2:0]                job request per requester
//   req_addr[95:0]              job byte address, 32 bits per requester
//   req_size[47:0]              job beats minus 1, 16 bits per requester
//   req_rdy[2:0]                job-accept pulse (combinational in IDLE)
//   req_done[2:0], req_err      job-complete pulse, err = aborted on timeout
//   dma_start                   chunk start pulse
//   dma_src_addr, dma_size      chunk byte address, chunk beats minus 1
//   dma_dat_en/wt_en/cfg_en     one-hot routing select for the active requester
//   dma_done                    last beat of the current chunk accepted
//   busy, cur_req               not idle, index of the active requester
module dma_job_sched #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT          = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req_vld,
  input  logic [95:0] req_addr,
  input  logic [47:0] req_size,
  output logic [2:0]  req_rdy,
  output logic [2:0]  req_done,
  output logic        req_err,
  output logic        dma_start,
  output logic [31:0] dma_src_addr,
  output logic [15:0] dma_size,
  output logic        dma_dat_en,
  output logic        dma_wt_en,
  output logic        dma_cfg_en,
  input  logic        dma_done,
  output logic        busy,
  output logic [1:0]  cur_req
);

  localparam int BPB = C_AXI_DATA_WIDTH / 8;
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    last_grant;
  logic [1:0]    cur_req_q;
  logic [31:0]   cur_addr;
  logic [16:0]   rem;        // remaining beats minus 1; 17 bits so rem+1 never wraps
  logic [TW-1:0] tcnt;

  // Round-robin search order, starting one past the last grant.
  logic [1:0] rr0, rr1, rr2;
  logic [1:0] gnt_idx;
  logic       gnt_any;

  always_comb begin
    rr0     = (last_grant >= 2'd2) ? 2'd0 : last_grant + 2'd1;
    rr1     = (rr0 == 2'd2) ? 2'd0 : rr0 + 2'd1;
    rr2     = (rr1 == 2'd2) ? 2'd0 : rr1 + 2'd1;
    gnt_any = |req_vld;
    if (req_vld[rr0])      gnt_idx = rr0;
    else if (req_vld[rr1]) gnt_idx = rr1;
    else                   gnt_idx = rr2;
  end

  // Chunk length: limited by what is left, the 256-beat cap and the beats to the next 4 KB line.
  logic [16:0] rem_p1;
  logic [16:0] b4k;
  logic [16:0] clen;
  logic        chunk_last;
  logic        timed_out;

  always_comb begin
    rem_p1 = rem + 17'd1;
    b4k    = 17'((32'd4096 - {20'd0, cur_addr[11:0]}) / BPB);
    clen   = rem_p1;
    if (clen > 17'd256) clen = 17'd256;
    if (clen > b4k)     clen = b4k;
    chunk_last = (rem_p1 == clen);
    timed_out  = (tcnt == TW'(TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 2'd2;
      cur_req_q  <= 2'd0;
      cur_addr   <= 32'd0;
      rem        <= 17'd0;
      tcnt       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            cur_addr   <= req_addr[32*gnt_idx +: 32];
            rem        <= {1'b0, req_size[16*gnt_idx +: 16]};
            cur_req_q  <= gnt_idx;
            last_grant <= gnt_idx;
          end
        end
        START: tcnt <= '0;
        WAIT: begin
          tcnt <= tcnt + 1'b1;
          if (dma_done && !chunk_last) begin
            rem      <= rem - clen;
            cur_addr <= cur_addr + 32'(clen) * 32'(BPB);
          end
        end
        default: ;
      endcase
    end
  end

  // Pulses are also forced low while rst_n is asserted so a job in flight never reports done.
  always_comb begin
    state_nxt = state;
    req_rdy   = 3'b000;
    req_done  = 3'b000;
    req_err   = 1'b0;
    dma_start = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          req_rdy   = 3'b001 << gnt_idx;
          state_nxt = START;
        end
      end
      START: begin
        dma_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // dma_done takes priority over a coincident timeout.
        if (dma_done) begin
          if (chunk_last) begin
            req_done  = 3'b001 << cur_req_q;
            state_nxt = IDLE;
          end else begin
            state_nxt = START;
          end
        end else if (timed_out) begin
          req_done  = 3'b001 << cur_req_q;
          req_err   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) begin
      req_rdy   = 3'b000;
      req_done  = 3'b000;
      req_err   = 1'b0;
      dma_start = 1'b0;
    end
  end

  // Chunk descriptor is derived from cur_addr/rem, which only move on WAIT->START,
  // so it is stable from START until the next START.
  assign busy         = (state != IDLE);
  assign dma_src_addr = busy ? cur_addr : 32'd0;
  assign dma_size     = busy ? 16'(clen - 17'd1) : 16'd0;
  assign {dma_cfg_en, dma_wt_en, dma_dat_en} = busy ? (3'b001 << cur_req_q) : 3'b000;
  assign cur_req      = cur_req_q;

endmodule

// File: tb/tb_dma_job_sched.sv
// tb/tb_dma_job_sched.sv - directed scoreboard bench for dma_job_sched
module tb_dma_job_sched;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req_vld = 3'b000;
  logic [95:0] req_addr = '0;
  logic [47:0] req_size = '0;
  logic [2:0]  req_rdy;
  logic [2:0]  req_done;
  logic        req_err;
  logic        dma_start;
  logic [31:0] dma_src_addr;
  logic [15:0] dma_size;
  logic        dma_dat_en;
  logic        dma_wt_en;
  logic        dma_cfg_en;
  logic        dma_done = 1'b0;
  logic        busy;
  logic [1:0]  cur_req;

  dma_job_sched #(.C_AXI_DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_vld      (req_vld),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_rdy      (req_rdy),
    .req_done     (req_done),
    .req_err      (req_err),
    .dma_start    (dma_start),
    .dma_src_addr (dma_src_addr),
    .dma_size     (dma_size),
    .dma_dat_en   (dma_dat_en),
    .dma_wt_en    (dma_wt_en),
    .dma_cfg_en   (dma_cfg_en),
    .dma_done     (dma_done),
    .busy         (busy),
    .cur_req      (cur_req)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] size;
    logic [2:0]  en;
  } chunk_t;

  typedef struct packed {
    logic [2:0] done;
    logic       err;
  } done_t;

  chunk_t     exp_chunks[$];
  done_t      exp_done[$];
  logic [1:0] exp_grant[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_chunk(input logic [31:0] a, input logic [15:0] s, input logic [2:0] en);
    chunk_t ch;
    ch.addr = a;
    ch.size = s;
    ch.en   = en;
    exp_chunks.push_back(ch);
  endtask

  task automatic push_done(input logic [2:0] d, input logic e);
    done_t dn;
    dn.done = d;
    dn.err  = e;
    exp_done.push_back(dn);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [15:0] s);
    req_addr[32*i +: 32] = a;
    req_size[16*i +: 16] = s;
  endtask

  // Called and returns at posedge+1. done_lat: WAIT cycles before dma_done (-1 never);
  // ghost: raise dma_done during START; stop_starts: return after that many dma_starts (0 = run to completion).
  task automatic run(input int done_lat, input bit ghost, input int stop_starts, input int budget);
    int     wcnt, wait_start, last_evt, n_starts;
    bit     in_wait, in_wait_now, grant_prev, grant_now, finished;
    bit     prev_rdy, prev_done, prev_start;
    logic [2:0] cur_en;
    logic [1:0] g;
    chunk_t ch;
    done_t  dn;
    wcnt = 0; wait_start = 0; last_evt = 0; n_starts = 0;
    in_wait = 0; grant_prev = 0; finished = 0;
    prev_rdy = 0; prev_done = 0; prev_start = 0;
    cur_en = 3'b000;
    for (int c = 0; c < budget; c++) begin
      in_wait_now = in_wait;
      dma_done = 1'b0;
      if (grant_prev && ghost) dma_done = 1'b1;
      if (in_wait && done_lat >= 0 && wcnt == done_lat) dma_done = 1'b1;
      #1;
      chk("single_cycle_pulses", {prev_rdy & (|req_rdy), prev_done & (|req_done), prev_start & dma_start}, 3'b000);
      grant_now = (req_rdy != 3'b000);
      if (grant_now) begin
        chk("grant_pending", exp_grant.size() != 0, 1);
        if (exp_grant.size() != 0) begin
          g = exp_grant.pop_front();
          chk("req_rdy", req_rdy, 3'b001 << g);
        end
        last_evt = c;
      end
      if (in_wait_now) begin
        chk("en_in_wait", {dma_cfg_en, dma_wt_en, dma_dat_en}, cur_en);
        chk("busy_in_wait", busy, 1);
      end
      if (dma_start) begin
        n_starts++;
        chk("start_latency", c - last_evt, 1);
        chk("chunk_pending", exp_chunks.size() != 0, 1);
        if (exp_chunks.size() != 0) begin
          ch = exp_chunks.pop_front();
          chk("dma_src_addr", dma_src_addr, ch.addr);
          chk("dma_size", dma_size, ch.size);
          chk("dma_en", {dma_cfg_en, dma_wt_en, dma_dat_en}, ch.en);
          cur_en = ch.en;
        end
        in_wait = 1;
        wcnt = 0;
        wait_start = c + 1;
      end
      if (req_done != 3'b000) begin
        chk("done_pending", exp_done.size() != 0, 1);
        if (exp_done.size() != 0) begin
          dn = exp_done.pop_front();
          chk("req_done", req_done, dn.done);
          chk("req_err", req_err, dn.err);
          if (dn.err) chk("timeout_latency", c - wait_start, TO);
          else        chk("done_same_cycle", dma_done, 1);
        end
        in_wait = 0;
      end
      if (dma_done && in_wait_now) begin
        last_evt = c;
        in_wait = 0;
      end
      if (in_wait_now && in_wait) wcnt++;
      prev_rdy   = (req_rdy != 3'b000);
      prev_done  = (req_done != 3'b000);
      prev_start = dma_start;
      grant_prev = grant_now;
      if (stop_starts > 0 && n_starts == stop_starts) finished = 1;
      if (stop_starts == 0 && exp_grant.size() == 0 && exp_chunks.size() == 0 && exp_done.size() == 0)
        finished = 1;
      @(posedge clk); #1;
      if (finished) break;
    end
    dma_done = 1'b0;
    chk("run_finished", finished, 1);
  endtask

  initial begin
    // Reset with requests and dma_done asserted: everything must stay quiet.
    rst_n = 1'b0; req_vld = 3'b111; dma_done = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_outputs", {req_rdy, req_done, req_err, dma_start, dma_src_addr, dma_size,
                          dma_cfg_en, dma_wt_en, dma_dat_en, busy, cur_req}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; req_vld = 3'b000;

    // dma_done in IDLE is ignored.
    repeat (2) begin
      @(posedge clk); #2;
      chk("idle_done_busy", busy, 0);
      chk("idle_done_req_done", req_done, 3'b000);
    end
    @(posedge clk); #1;
    dma_done = 1'b0;
    @(posedge clk); #1;

    // Single job on dat, with a stray dma_done during START.
    set_req(0, 32'h1000, 16'd15);
    req_vld = 3'b001;
    exp_grant.push_back(2'd0);
    push_chunk(32'h1000, 16'd15, 3'b001);
    push_done(3'b001, 1'b0);
    run(2, 1, 0, 200);
    req_vld = 3'b000;
    @(posedge clk); #1;

    // 600-beat job on wt splits at the 256-beat cap.
    set_req(1, 32'h0, 16'd599);
    req_vld = 3'b010;
    exp_grant.push_back(2'd1);
    push_chunk(32'h0000, 16'd255, 3'b010);
    push_chunk(32'h0400, 16'd255, 3'b010);
    push_chunk(32'h0800, 16'd87, 3'b010);
    push_done(3'b010, 1'b0);
    run(0, 0, 0, 200);
    req_vld = 3'b000;
    @(posedge clk); #1;

    // 4 KB crossing on cfg.
    set_req(2, 32'h0FF0, 16'd15);
    req_vld = 3'b100;
    exp_grant.push_back(2'd2);
    push_chunk(32'h0FF0, 16'd3, 3'b100);
    push_chunk(32'h1000, 16'd11, 3'b100);
    push_done(3'b100, 1'b0);
    run(1, 0, 0, 200);
    req_vld = 3'b000;
    @(posedge clk); #1;

    // All three requesting and held: grant order 0, 1, 2.
    set_req(0, 32'h2000, 16'd3);
    set_req(1, 32'h3000, 16'd7);
    set_req(2, 32'h4000, 16'd0);
    req_vld = 3'b111;
    exp_grant.push_back(2'd0);
    exp_grant.push_back(2'd1);
    exp_grant.push_back(2'd2);
    push_chunk(32'h2000, 16'd3, 3'b001);
    push_done(3'b001, 1'b0);
    push_chunk(32'h3000, 16'd7, 3'b010);
    push_done(3'b010, 1'b0);
    push_chunk(32'h4000, 16'd0, 3'b100);
    push_done(3'b100, 1'b0);
    run(1, 0, 0, 300);
    req_vld = 3'b000;
    @(posedge clk); #1;

    // Timeout with dma_done never asserted.
    set_req(0, 32'h5000, 16'd9);
    req_vld = 3'b001;
    exp_grant.push_back(2'd0);
    push_chunk(32'h5000, 16'd9, 3'b001);
    push_done(3'b001, 1'b1);
    run(-1, 0, 0, 200);
    req_vld = 3'b000;
    @(posedge clk); #1;

    // dma_done in the same cycle as the timeout completes normally.
    set_req(1, 32'h6000, 16'd1);
    req_vld = 3'b010;
    exp_grant.push_back(2'd1);
    push_chunk(32'h6000, 16'd1, 3'b010);
    push_done(3'b010, 1'b0);
    run(TO, 0, 0, 200);
    req_vld = 3'b000;
    @(posedge clk); #1;

    // Reset during WAIT of the second chunk of a split job.
    set_req(1, 32'h0, 16'd599);
    req_vld = 3'b010;
    exp_grant.push_back(2'd1);
    push_chunk(32'h0000, 16'd255, 3'b010);
    push_chunk(32'h0400, 16'd255, 3'b010);
    push_chunk(32'h0800, 16'd87, 3'b010);
    push_done(3'b010, 1'b0);
    run(3, 0, 2, 200);
    req_vld = 3'b000;
    rst_n = 1'b0;
    #1;
    chk("reset_wait_no_done", req_done, 3'b000);
    @(posedge clk); #2;
    chk("reset_wait_outputs", {req_rdy, req_done, req_err, dma_start, dma_src_addr, dma_size,
                               dma_cfg_en, dma_wt_en, dma_dat_en, busy, cur_req}, 64'd0);
    exp_chunks.delete();
    exp_done.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // After reset, requester 0 wins over requester 2.
    set_req(0, 32'h7000, 16'd0);
    set_req(2, 32'h8000, 16'd0);
    req_vld = 3'b101;
    exp_grant.push_back(2'd0);
    exp_grant.push_back(2'd2);
    push_chunk(32'h7000, 16'd0, 3'b001);
    push_done(3'b001, 1'b0);
    push_chunk(32'h8000, 16'd0, 3'b100);
    push_done(3'b100, 1'b0);
    run(0, 0, 0, 200);
    req_vld = 3'b000;
    @(posedge clk); #2;
    chk("final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_job_sched.md
DMA_JOB_SCHED -- requirements
Module: dma_job_sched

Interface
REQ-001 SHALL provide parameter C_AXI_DATA_WIDTH, default 32, meaning the data beat width in bits; bytes per beat BPB = C_AXI_DATA_WIDTH/8.
REQ-002 SHALL provide parameter TIMEOUT, default 65535, meaning the maximum number of cycles spent in WAIT before a chunk is abandoned.
REQ-003 SHALL use a single clock, clk; reset rst_n is synchronous and active-low.
REQ-004 Ports, in this order:
  clk  in  1  clock
  rst_n  in  1  synchronous active-low reset
  req_vld  in  3  job request per requester: bit0 dat, bit1 wt, bit2 cfg
  req_addr  in  96  byte address of the job, 32 bits per requester, requester i at [32i+31:32i]
  req_size  in  48  beats minus 1, 16 bits per requester, requester i at [16i+15:16i]
  req_rdy  out  3  one-cycle job-accept pulse
  req_done  out  3  one-cycle job-complete pulse
  req_err  out  1  valid with req_done; 1 = job aborted on timeout
  dma_start  out  1  one-cycle chunk start to the DMA
  dma_src_addr  out  32  chunk byte address
  dma_size  out  16  chunk beats minus 1; upper 8 bits always 0
  dma_dat_en / dma_wt_en / dma_cfg_en  out  1 each  one-hot routing select
  dma_done  in  1  last beat of the current chunk accepted
  busy  out  1  FSM not in IDLE
  cur_req  out  2  index of the active requester

Function
REQ-005 FSM states SHALL be IDLE, START, WAIT.
REQ-006 IDLE, any req_vld high: the block SHALL grant round-robin, searching from (last_grant+1) mod 3.
  Same cycle: pulse req_rdy[i].
  Next edge: latch cur_addr = req_addr_i, rem = req_size_i (17 bits), cur_req = i, last_grant = i; go to START.
REQ-007 Chunk length SHALL be clen = min(rem+1, 256, b4k), where b4k = (4096 - cur_addr[11:0])/BPB.
  Addresses are BPB-aligned; unaligned addresses are a caller error and the behaviour is undefined.
REQ-008 START SHALL assert dma_start for exactly one cycle with dma_src_addr = cur_addr and dma_size = clen-1, then go to WAIT.
REQ-009 dma_src_addr and dma_size SHALL hold their values from START until the next START or IDLE.
REQ-010 WAIT, on dma_done:
  If rem+1 == clen: pulse req_done[cur_req] with req_err = 0; go to IDLE.
  Otherwise: rem -= clen; cur_addr += clen*BPB; go to START.
REQ-011 A WAIT cycle counter SHALL clear on entry to WAIT.
  If it reaches TIMEOUT without dma_done: pulse req_done[cur_req] with req_err = 1; go to IDLE.
REQ-012 If dma_done and the timeout occur in the same cycle, dma_done SHALL win (normal completion).
REQ-013 dma_done in IDLE or START SHALL be ignored.
REQ-014 req_vld changes after acceptance SHALL have no effect; a new request is evaluated only in IDLE.
REQ-015 The dma_*_en bit for cur_req SHALL be 1 in START and WAIT, all en bits SHALL be 0 in IDLE, and busy SHALL equal (state != IDLE).
REQ-016 Minimum latency SHALL be: req_vld to req_rdy 0 cycles (combinational in IDLE); req_rdy to dma_start 1 cycle; dma_done to req_done 0 cycles (same-cycle pulse); dma_done to next-chunk dma_start 1 cycle.
REQ-017 req_rdy, req_done and dma_start SHALL never be high for more than one consecutive cycle.

Reset
REQ-018 While rst_n = 0 at a clk edge:
  State SHALL go to IDLE and last_grant SHALL be 2.
  rem, cur_addr and the timeout counter SHALL clear.
  All outputs SHALL be 0.
REQ-019 Reset mid-job SHALL discard the job with no req_done pulse; the requester must re-request.

Verification
REQ-020 Single job: req_vld=001, addr 0x1000, size 15 -> req_rdy=001; one dma_start with addr 0x1000, size 15, dma_dat_en=1; after dma_done -> req_done=001, req_err=0.
REQ-021 Split job: wt, addr 0x0, size 599 (600 beats) -> three chunks at 0x0/size 255, 0x400/size 255, 0x800/size 87; req_done once, after the third dma_done.
REQ-022 4 KB crossing: addr 0x0FF0, size 15 -> chunk 0x0FF0/size 3, then 0x1000/size 11.
REQ-023 Arbitration: req_vld=111 held through three jobs -> grant order 0, 1, 2; the cfg job drives dma_cfg_en only.
REQ-024 Timeout: TIMEOUT=16, dma_done never asserted -> req_done with req_err=1 exactly 16 cycles after entering WAIT; a same-cycle dma_done/timeout gives req_err=0.
REQ-025 Reset asserted during WAIT of a split job -> all outputs 0 next cycle, no req_done; the next request from requester 0 is granted first.
